// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin mux arbiter.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    // Output register occupancy: EMPTY means out_valid=0, FULL means out_valid=1.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Expand a 2-bit requester index into its one-hot grant vector.
    function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] sel);
        onehot4 = NUM_REQ'(1) << sel;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: scans last+1, last+2, last+3, last (mod 4)
// and returns the first requesting index, so the previous winner ranks lowest.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               any,
    output logic [SEL_W-1:0]   winner
);

    logic [SEL_W-1:0] idx;
    logic             found;

    // Rotating priority scan; the 2-bit index wraps naturally from 3 back to 0.
    always_comb begin
        any    = |req;
        winner = last;
        idx    = '0;
        found  = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = last + SEL_W'(i);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux between four requesters, with a
// registered valid/ready output stage toward a single consumer.
// Optional burst lock: define ARB_LOCK_EN to add the 'lock' input port.
module rr_mux4_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic               clk,
    input  logic               rst,
`ifdef ARB_LOCK_EN
    input  logic [NUM_REQ-1:0] lock,
`endif
    input  logic [NUM_REQ-1:0] req,
    input  logic [DATA_W-1:0]  din0,
    input  logic [DATA_W-1:0]  din1,
    input  logic [DATA_W-1:0]  din2,
    input  logic [DATA_W-1:0]  din3,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] grant,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [SEL_W-1:0]   last_q, last_d;

    logic               pick_any;
    logic [SEL_W-1:0]   pick_winner;
    logic [SEL_W-1:0]   winner;
    logic               cap;

    rr_pick4 u_pick (
        .req    (req),
        .last   (last_q),
        .any    (pick_any),
        .winner (pick_winner)
    );

    // Final winner: a locked, still-requesting last winner keeps the mux; otherwise round-robin.
    always_comb begin
`ifdef ARB_LOCK_EN
        winner = (lock[last_q] && req[last_q]) ? last_q : pick_winner;
`else
        winner = pick_winner;
`endif
        cap = pick_any && ((state_q == EMPTY) || out_ready);
    end

    // State, data and pointer registers; reset leaves requester 0 with top priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            sel_q      <= '0;
            grant_q    <= '0;
            last_q     <= SEL_W'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
        end
    end

    // Next state: a capture always fills the register, an accept with no capture drains it.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        last_d     = last_q;
        if (cap) begin
            state_d = FULL;
            unique case (winner)
                2'd0:    out_data_d = din0;
                2'd1:    out_data_d = din1;
                2'd2:    out_data_d = din2;
                default: out_data_d = din3;
            endcase
            sel_d   = winner;
            grant_d = onehot4(winner);
            last_d  = winner;
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
            grant_d = '0;
        end
    end

    // Outputs: registered view of the transfer plus the same-cycle acknowledge to the winner.
    always_comb begin
        out_valid = (state_q == FULL);
        out_data  = out_data_q;
        sel       = sel_q;
        grant     = grant_q;
        req_ready = (cap && !rst) ? onehot4(winner) : '0;
    end

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Directed self-checking bench for rr_mux4_arbiter (burst lock steps compile
// only when ARB_LOCK_EN is defined).
module tb_rr_mux4_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] din0, din1, din2, din3;
   logic [3:0] reqReady;
   logic [1:0] sel;
   logic [3:0] grant;
   logic [3:0] outData;
   logic       outValid;
   logic       outReady;
`ifdef ARB_LOCK_EN
   logic [3:0] lock;
`endif

   int testCount = 0;
   int failCount = 0;

   rr_mux4_arbiter #(.DATA_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef ARB_LOCK_EN
      .lock      (lock),
`endif
      .req       (req),
      .din0      (din0),
      .din1      (din1),
      .din2      (din2),
      .din3      (din3),
      .req_ready (reqReady),
      .sel       (sel),
      .grant     (grant),
      .out_data  (outData),
      .out_valid (outValid),
      .out_ready (outReady)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive the request vector and the downstream ready.
   task automatic applyStimulus(input logic [3:0] r, input logic rdy);
      req      = r;
      outReady = rdy;
   endtask

   // Advance one clock and settle a little past the edge before sampling.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // One comparison: counts it, and reports it on mismatch.
   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Registered outputs checked as a group.
   task automatic checkRegs(input string tag, input logic v, input logic [3:0] d,
                            input logic [1:0] s, input logic [3:0] g);
      checkOutput({tag, ".out_valid"}, {7'd0, outValid}, {7'd0, v});
      checkOutput({tag, ".out_data"},  {4'd0, outData},  {4'd0, d});
      checkOutput({tag, ".sel"},       {6'd0, sel},      {6'd0, s});
      checkOutput({tag, ".grant"},     {4'd0, grant},    {4'd0, g});
   endtask

   task automatic checkReady(input string tag, input logic [3:0] exp);
      #1;
      checkOutput({tag, ".req_ready"}, {4'd0, reqReady}, {4'd0, exp});
   endtask

   // Async reset pulse between clock edges, checking outputs clear immediately.
   task automatic pulseReset(input string tag);
      rst = 1'b1;
      #1;
      checkOutput({tag, ".out_valid"}, {7'd0, outValid}, 8'd0);
      checkOutput({tag, ".grant"},     {4'd0, grant},    8'd0);
      checkOutput({tag, ".req_ready"}, {4'd0, reqReady}, 8'd0);
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      din0 = 4'h0; din1 = 4'h0; din2 = 4'h0; din3 = 4'h0;
`ifdef ARB_LOCK_EN
      lock = 4'b0000;
`endif
      applyStimulus(4'b1111, 1'b1);

      // Reset state, with every requester asking: nothing acknowledged.
      #12;
      checkRegs("reset", 1'b0, 4'h0, 2'd0, 4'b0000);
      checkOutput("reset.req_ready", {4'd0, reqReady}, 8'd0);
      rst = 1'b0;
      #1;

      // Single request right after reset: requester 0, one-cycle latency.
      din0 = 4'hA;
      applyStimulus(4'b0001, 1'b1);
      checkReady("first", 4'b0001);
      tick();
      checkRegs("first", 1'b1, 4'hA, 2'd0, 4'b0001);

      // Reset while the output holds a transfer discards it.
      pulseReset("rstFull");
      checkRegs("rstFullRegs", 1'b0, 4'h0, 2'd0, 4'b0000);

      // All four requesting with ready high: one transfer per cycle, rotating.
      din0 = 4'h1; din1 = 4'h2; din2 = 4'h3; din3 = 4'h4;
      applyStimulus(4'b1111, 1'b1);
      for (int k = 0; k < 5; k++) begin
         logic [1:0] w;
         w = 2'(k % 4);
         checkReady($sformatf("rr%0d", k), 4'b0001 << w);
         tick();
         checkRegs($sformatf("rr%0d", k), 1'b1, 4'(w + 1), w, 4'b0001 << w);
      end

      // Accept with no new request: valid and grant drop, sel and data hold.
      applyStimulus(4'b0000, 1'b1);
      checkReady("drain", 4'b0000);
      tick();
      checkRegs("drain", 1'b0, 4'h1, 2'd0, 4'b0000);

      // Capture then stall for three cycles; pending requests are not acknowledged.
      applyStimulus(4'b0110, 1'b1);
      checkReady("stallCap", 4'b0010);
      tick();
      checkRegs("stallCap", 1'b1, 4'h2, 2'd1, 4'b0010);
      outReady = 1'b0;
      for (int k = 0; k < 3; k++) begin
         checkReady($sformatf("stall%0d", k), 4'b0000);
         tick();
         checkRegs($sformatf("stall%0d", k), 1'b1, 4'h2, 2'd1, 4'b0010);
      end
      outReady = 1'b1;
      checkReady("release", 4'b0100);
      tick();
      checkRegs("release", 1'b1, 4'h3, 2'd2, 4'b0100);

      // Pointer at 2 with requests 0 and 2: search order 3,0,1,2 picks 0.
      applyStimulus(4'b0101, 1'b1);
      checkReady("wrap", 4'b0001);
      tick();
      checkRegs("wrap", 1'b1, 4'h1, 2'd0, 4'b0001);

      // Reset restores requester 0 as top priority over requester 3.
      pulseReset("rstPrio");
      applyStimulus(4'b1001, 1'b1);
      checkReady("prio0", 4'b0001);
      tick();
      checkRegs("prio0", 1'b1, 4'h1, 2'd0, 4'b0001);
      applyStimulus(4'b1000, 1'b1);
      checkReady("prio3", 4'b1000);
      tick();
      checkRegs("prio3", 1'b1, 4'h4, 2'd3, 4'b1000);

      // Lone requester wins every capture even though it was last granted.
      applyStimulus(4'b0100, 1'b1);
      for (int k = 0; k < 2; k++) begin
         checkReady($sformatf("single%0d", k), 4'b0100);
         tick();
         checkRegs($sformatf("single%0d", k), 1'b1, 4'h3, 2'd2, 4'b0100);
      end
      applyStimulus(4'b0000, 1'b1);
      tick();
      checkRegs("idle", 1'b0, 4'h3, 2'd2, 4'b0000);

`ifdef ARB_LOCK_EN
      // Burst lock on requester 0 keeps it granted until the lock falls.
      pulseReset("rstLock");
      lock = 4'b0001;
      applyStimulus(4'b0011, 1'b1);
      for (int k = 0; k < 4; k++) begin
         checkReady($sformatf("lock%0d", k), 4'b0001);
         tick();
         checkRegs($sformatf("lock%0d", k), 1'b1, 4'h1, 2'd0, 4'b0001);
      end
      lock = 4'b0000;
      checkReady("unlock", 4'b0010);
      tick();
      checkRegs("unlock", 1'b1, 4'h2, 2'd1, 4'b0010);
`endif

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
